// File: rtl/npu_core.sv
// Two-neuron inference core: operand latch, dual MAC, scaled/saturating ReLU,
// argmax, output/debug shift registers and a result FIFO muxed onto one byte.
module npu_core #(
  parameter int ACC_W      = 20,
  parameter int RELU_SHIFT = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLKEXT,
  input  logic              RST,
  input  logic signed [7:0] DA,
  input  logic signed [7:0] DB,
  input  logic signed [7:0] DC,
  input  logic signed [7:0] DD,
  input  logic              RD_EN,
  input  logic [15:0]       SSFR,
  input  logic [15:0]       CON_SIG,
  input  logic              SHIFT_DEB,
  input  logic              EN_PISO_DEB,
  input  logic              CLR_PISO_DEB,
  output logic [7:0]        DATA_OUT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [2:0] selOut;
  logic       bypassRelu1, bypassRelu2, enComp;
  logic       enBufIn, clrBuf, enMac, clrMac, enRelu;
  logic       shiftOut, enPisoOut, clrPisoOut, wrEn;
  logic       unusedBits;

  assign selOut      = SSFR[15:13];
  assign bypassRelu1 = SSFR[12];
  assign bypassRelu2 = SSFR[11];
  assign enComp      = SSFR[10];
  assign enBufIn     = CON_SIG[15];
  assign clrBuf      = CON_SIG[14];
  assign enMac       = CON_SIG[13];
  assign clrMac      = CON_SIG[12];
  assign enRelu      = CON_SIG[11];
  assign shiftOut    = CON_SIG[10];
  assign enPisoOut   = CON_SIG[9];
  assign clrPisoOut  = CON_SIG[8];
  assign wrEn        = CON_SIG[7];
  assign unusedBits  = ^{SSFR[9:0], CON_SIG[6:0]};

  logic signed [7:0]       bufA_q, bufB_q, bufC_q, bufD_q;
  logic signed [7:0]       bufA_d, bufB_d, bufC_d, bufD_d;
  logic signed [ACC_W-1:0] acc1_q, acc2_q, acc1_d, acc2_d;
  logic [7:0]              relu1_q, relu2_q, relu1_d, relu2_d;
  logic [7:0]              largest_q, largest_d;
  logic                    index_q, index_d;
  logic [15:0]             pisoOut_q, pisoOut_d;
  logic [31:0]             pisoDeb_q, pisoDeb_d;
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PTR_W:0]          count_q, count_d;
  logic [7:0]              fifoQ_q, fifoQ_d;
  logic [7:0]              fifoMem [FIFO_DEPTH];

  logic signed [15:0]      prod1, prod2;
  logic                    doRead, doWrite;
  logic [7:0]              pisoOutHead, pisoDebHead;

  assign prod1       = bufA_q * bufB_q;
  assign prod2       = bufC_q * bufD_q;
  assign pisoOutHead = pisoOut_q[15:8];
  assign pisoDebHead = pisoDeb_q[31:24];

  // Clamp to 0..255 unless bypassed, in which case the raw low byte passes.
  function automatic logic [7:0] reluFn(input logic signed [ACC_W-1:0] acc,
                                        input logic bypass);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> RELU_SHIFT;
    if (bypass)                      return shifted[7:0];
    else if (shifted[ACC_W-1])       return 8'd0;
    else if (|shifted[ACC_W-2:8])    return 8'hFF;
    else                             return shifted[7:0];
  endfunction

  always_comb begin
    bufA_d = bufA_q;
    bufB_d = bufB_q;
    bufC_d = bufC_q;
    bufD_d = bufD_q;
    if (clrBuf) begin
      bufA_d = '0;
      bufB_d = '0;
      bufC_d = '0;
      bufD_d = '0;
    end else if (enBufIn) begin
      bufA_d = DA;
      bufB_d = DB;
      bufC_d = DC;
      bufD_d = DD;
    end
  end

  always_comb begin
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    if (clrMac) begin
      acc1_d = '0;
      acc2_d = '0;
    end else if (enMac) begin
      acc1_d = acc1_q + {{(ACC_W-16){prod1[15]}}, prod1};
      acc2_d = acc2_q + {{(ACC_W-16){prod2[15]}}, prod2};
    end
  end

  always_comb begin
    relu1_d   = relu1_q;
    relu2_d   = relu2_q;
    largest_d = largest_q;
    index_d   = index_q;
    if (enRelu) begin
      relu1_d = reluFn(acc1_q, bypassRelu1);
      relu2_d = reluFn(acc2_q, bypassRelu2);
    end
    // Ties favour neuron 0.
    if (enComp) begin
      if (relu1_q >= relu2_q) begin
        largest_d = relu1_q;
        index_d   = 1'b0;
      end else begin
        largest_d = relu2_q;
        index_d   = 1'b1;
      end
    end
  end

  always_comb begin
    pisoOut_d = pisoOut_q;
    pisoDeb_d = pisoDeb_q;
    if (clrPisoOut)                 pisoOut_d = '0;
    else if (enPisoOut && shiftOut) pisoOut_d = {pisoOut_q[7:0], 8'h00};
    else if (enPisoOut)             pisoOut_d = {relu1_q, relu2_q};
    if (clrPisoDebSafe())           pisoDeb_d = '0;
    else if (EN_PISO_DEB && SHIFT_DEB) pisoDeb_d = {pisoDeb_q[23:0], 8'h00};
    else if (EN_PISO_DEB)           pisoDeb_d = {acc1_q[15:0], acc2_q[15:0]};
  end

  function automatic logic clrPisoDebSafe();
    return CLR_PISO_DEB;
  endfunction

  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign doRead  = RD_EN && (count_q != '0);
  assign doWrite = wrEn && ((count_q != FULL_CNT) || doRead);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    fifoQ_d = fifoQ_q;
    if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
    if (doRead) begin
      rdPtr_d = rdPtr_q + 1'b1;
      fifoQ_d = fifoMem[rdPtr_q];
    end
    case ({doWrite, doRead})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      bufA_q    <= '0;
      bufB_q    <= '0;
      bufC_q    <= '0;
      bufD_q    <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      relu1_q   <= '0;
      relu2_q   <= '0;
      largest_q <= '0;
      index_q   <= 1'b0;
      pisoOut_q <= '0;
      pisoDeb_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      fifoQ_q   <= '0;
    end else begin
      bufA_q    <= bufA_d;
      bufB_q    <= bufB_d;
      bufC_q    <= bufC_d;
      bufD_q    <= bufD_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      relu1_q   <= relu1_d;
      relu2_q   <= relu2_d;
      largest_q <= largest_d;
      index_q   <= index_d;
      pisoOut_q <= pisoOut_d;
      pisoDeb_q <= pisoDeb_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      fifoQ_q   <= fifoQ_d;
    end
  end

  // Storage needs no reset: only entries written since reset are ever read.
  always_ff @(posedge CLKEXT) begin
    if (!RST && doWrite) fifoMem[wrPtr_q] <= pisoOutHead;
  end

  always_comb begin
    DATA_OUT = 8'h00;
    case (selOut)
      3'd0:    DATA_OUT = fifoQ_q;
      3'd1:    DATA_OUT = pisoOutHead;
      3'd2:    DATA_OUT = {7'b0, index_q};
      3'd3:    DATA_OUT = largest_q;
      3'd4:    DATA_OUT = pisoDebHead;
      default: DATA_OUT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_npu_core.sv
// Directed self-checking bench for npu_core: hand-computed MAC/ReLU/argmax,
// PISO and FIFO results observed through every DATA_OUT select.
module tb_npu_core;

  localparam logic [15:0] EN_BUF   = 16'h8000;
  localparam logic [15:0] CLR_BUF  = 16'h4000;
  localparam logic [15:0] EN_MAC   = 16'h2000;
  localparam logic [15:0] CLR_MAC  = 16'h1000;
  localparam logic [15:0] EN_RELU  = 16'h0800;
  localparam logic [15:0] SHIFT_O  = 16'h0400;
  localparam logic [15:0] EN_PISO  = 16'h0200;
  localparam logic [15:0] CLR_PISO = 16'h0100;
  localparam logic [15:0] WR       = 16'h0080;
  localparam logic [15:0] BYP1     = 16'h1000;
  localparam logic [15:0] EN_CMP   = 16'h0400;
  localparam logic [2:0]  DEB_LOAD  = 3'b010;
  localparam logic [2:0]  DEB_SHIFT = 3'b110;
  localparam logic [2:0]  DEB_CLR   = 3'b001;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] da, db, dc, dd;
  logic              rdEn;
  logic [15:0]       ssfr, conSig;
  logic              shiftDeb, enPisoDeb, clrPisoDeb;
  logic [7:0]        dataOut;

  int checks = 0;
  int errors = 0;

  npu_core dut (
    .CLKEXT(clk), .RST(rst),
    .DA(da), .DB(db), .DC(dc), .DD(dd),
    .RD_EN(rdEn), .SSFR(ssfr), .CON_SIG(conSig),
    .SHIFT_DEB(shiftDeb), .EN_PISO_DEB(enPisoDeb), .CLR_PISO_DEB(clrPisoDeb),
    .DATA_OUT(dataOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // One clock of control, then return all strobes to idle.
  task automatic applyStimulus(input logic [15:0] con, input logic [15:0] ctl,
                               input logic [2:0] deb, input logic rd);
    conSig = con;
    ssfr   = {ssfr[15:13], ctl[12:0]};
    {shiftDeb, enPisoDeb, clrPisoDeb} = deb;
    rdEn   = rd;
    @(posedge clk);
    #1;
    conSig = '0;
    ssfr   = {ssfr[15:13], 13'b0};
    {shiftDeb, enPisoDeb, clrPisoDeb} = 3'b000;
    rdEn   = 1'b0;
  endtask

  task automatic checkSel(input logic [2:0] sel, input string tag,
                          input logic [7:0] expected);
    ssfr[15:13] = sel;
    #1;
    checkOutput(tag, dataOut, expected);
  endtask

  task automatic loadOperands(input logic signed [7:0] a, b, c, d);
    da = a; db = b; dc = c; dd = d;
    applyStimulus(CLR_MAC, '0, 3'b000, 1'b0);
    applyStimulus(EN_BUF, '0, 3'b000, 1'b0);
    applyStimulus(EN_MAC, '0, 3'b000, 1'b0);
    applyStimulus(EN_MAC, '0, 3'b000, 1'b0);
  endtask

  logic [15:0] fifoOps [9];
  logic [7:0]  fifoExp [8];

  initial begin
    rst = 1'b1; da = '0; db = '0; dc = '0; dd = '0; rdEn = 1'b0;
    ssfr = '0; conSig = '0; shiftDeb = 1'b0; enPisoDeb = 1'b0; clrPisoDeb = 1'b0;
    applyStimulus('0, '0, 3'b000, 1'b0);
    applyStimulus('0, '0, 3'b000, 1'b0);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) checkSel(3'(s), $sformatf("reset_sel%0d", s), 8'h00);

    // 10*20*2 = 400 -> 25; 30*40*2 = 2400 -> 150.
    loadOperands(8'sd10, 8'sd20, 8'sd30, 8'sd40);
    applyStimulus(EN_RELU, '0, 3'b000, 1'b0);
    applyStimulus('0, EN_CMP, 3'b000, 1'b0);
    checkSel(3'd3, "largest_pos", 8'h96);
    checkSel(3'd2, "index_pos", 8'h01);

    applyStimulus(EN_PISO, '0, 3'b000, 1'b0);
    checkSel(3'd1, "piso_load", 8'h19);
    applyStimulus(EN_PISO | SHIFT_O, '0, 3'b000, 1'b0);
    checkSel(3'd1, "piso_shift1", 8'h96);
    applyStimulus(EN_PISO | SHIFT_O, '0, 3'b000, 1'b0);
    checkSel(3'd1, "piso_shift2", 8'h00);

    checkSel(3'd4, "deb_pre", 8'h00);
    applyStimulus('0, '0, DEB_LOAD, 1'b0);
    checkSel(3'd4, "deb_load", 8'h01);
    applyStimulus('0, '0, DEB_SHIFT, 1'b0);
    checkSel(3'd4, "deb_shift1", 8'h90);
    applyStimulus('0, '0, DEB_SHIFT, 1'b0);
    checkSel(3'd4, "deb_shift2", 8'h09);
    applyStimulus('0, '0, DEB_SHIFT, 1'b0);
    checkSel(3'd4, "deb_shift3", 8'h60);
    applyStimulus('0, '0, DEB_CLR, 1'b0);
    checkSel(3'd4, "deb_clr", 8'h00);

    applyStimulus(EN_PISO, '0, 3'b000, 1'b0);
    applyStimulus(WR, '0, 3'b000, 1'b0);
    checkSel(3'd0, "fifo_before_read", 8'h00);
    applyStimulus('0, '0, 3'b000, 1'b1);
    checkSel(3'd0, "fifo_read1", 8'h19);
    applyStimulus('0, '0, 3'b000, 1'b1);
    checkSel(3'd0, "fifo_empty_read", 8'h19);

    // Head sequence 00,19,96 repeating; the ninth push (0x96) must be dropped.
    applyStimulus(CLR_PISO, '0, 3'b000, 1'b0);
    for (int i = 0; i < 9; i++) fifoOps[i] = (i % 3 == 0) ? EN_PISO : (EN_PISO | SHIFT_O);
    for (int i = 0; i < 8; i++) fifoExp[i] = (i % 3 == 0) ? 8'h00 : ((i % 3 == 1) ? 8'h19 : 8'h96);
    for (int i = 0; i < 9; i++) applyStimulus(WR | fifoOps[i], '0, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus('0, '0, 3'b000, 1'b1);
      checkSel(3'd0, $sformatf("fifo_pop%0d", i), fifoExp[i]);
    end
    applyStimulus('0, '0, 3'b000, 1'b1);
    checkSel(3'd0, "fifo_pop_over", 8'h19);
    // Head is 0x00 now; read+write on empty performs only the write.
    applyStimulus(WR, '0, 3'b000, 1'b1);
    checkSel(3'd0, "fifo_rdwr_empty", 8'h19);
    applyStimulus('0, '0, 3'b000, 1'b1);
    checkSel(3'd0, "fifo_rdwr_pop", 8'h00);

    // -3*10*2 = -60 -> >>>4 = -4; 5*2*2 = 20 -> 1.
    loadOperands(-8'sd3, 8'sd10, 8'sd5, 8'sd2);
    applyStimulus('0, '0, DEB_LOAD, 1'b0);
    checkSel(3'd4, "deb_neg_acc", 8'hFF);
    applyStimulus(EN_RELU, '0, 3'b000, 1'b0);
    applyStimulus('0, EN_CMP, 3'b000, 1'b0);
    checkSel(3'd3, "largest_relu", 8'h01);
    checkSel(3'd2, "index_relu", 8'h01);
    applyStimulus(EN_PISO, '0, 3'b000, 1'b0);
    checkSel(3'd1, "relu1_clamped", 8'h00);
    applyStimulus(EN_PISO | SHIFT_O, '0, 3'b000, 1'b0);
    checkSel(3'd1, "relu2_small", 8'h01);
    applyStimulus(EN_RELU, BYP1, 3'b000, 1'b0);
    applyStimulus('0, EN_CMP, 3'b000, 1'b0);
    checkSel(3'd3, "largest_bypass", 8'hFC);
    checkSel(3'd2, "index_bypass", 8'h00);
    applyStimulus(EN_PISO, '0, 3'b000, 1'b0);
    checkSel(3'd1, "relu1_bypass", 8'hFC);

    loadOperands(8'sd7, 8'sd9, 8'sd11, 8'sd13);
    applyStimulus(WR, '0, DEB_LOAD, 1'b0);
    applyStimulus('0, '0, 3'b000, 1'b1);
    rst = 1'b1;
    applyStimulus(EN_MAC | EN_RELU | EN_PISO | WR, EN_CMP, DEB_LOAD, 1'b1);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) checkSel(3'(s), $sformatf("midrst_sel%0d", s), 8'h00);

    // 5*2*2 = 20 -> 1; 8*3*2 = 48 -> 3.
    loadOperands(8'sd5, 8'sd2, 8'sd8, 8'sd3);
    applyStimulus(EN_RELU, '0, 3'b000, 1'b0);
    applyStimulus('0, EN_CMP, 3'b000, 1'b0);
    checkSel(3'd2, "index_after_rst", 8'h01);
    checkSel(3'd3, "largest_after_rst", 8'h03);
    applyStimulus(EN_PISO, '0, 3'b000, 1'b0);
    checkSel(3'd1, "relu1_after_rst", 8'h01);
    applyStimulus(EN_PISO | SHIFT_O, '0, 3'b000, 1'b0);
    checkSel(3'd1, "relu2_after_rst", 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
